// File: rtl/w_reg_write_stage.sv
`default_nettype none
// ============================================================================
// Module      : w_reg_write_stage
// Description : W pipeline register and register-file writeback mux with
//               optional load-data extension (build macro W_LOAD_EXT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module w_reg_write_stage #(
    parameter int DATA_W   = 32,
    parameter int NSRC     = 4,
    parameter int SEL_W    = 3,
    parameter int LOAD_IDX = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   m_valid,
    input  logic                   m_we,
    input  logic [4:0]             m_rd,
    input  logic [SEL_W-1:0]       m_sel,
    input  logic [NSRC*DATA_W-1:0] m_src,
    input  logic [1:0]             m_addr_lo,
    input  logic [2:0]             m_ld_type,
    output logic                   w_rf_we,
    output logic [4:0]             w_rf_addr,
    output logic [DATA_W-1:0]      w_rf_wdata,
    output logic                   w_valid
);

    localparam logic [2:0] c_LD_LB  = 3'd1;
    localparam logic [2:0] c_LD_LBU = 3'd2;
    localparam logic [2:0] c_LD_LH  = 3'd3;
    localparam logic [2:0] c_LD_LHU = 3'd4;

    logic                   r_valid;
    logic                   r_we;
    logic [4:0]             r_rd;
    logic [SEL_W-1:0]       r_sel;
    logic [NSRC*DATA_W-1:0] r_src;
    logic [1:0]             r_addrLo;
    logic [2:0]             r_ldType;

    // Flush wins over stall so a squashed instruction can never be held in W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_sel    <= '0;
            r_src    <= '0;
            r_addrLo <= '0;
            r_ldType <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
        end else if (!stall) begin
            r_valid  <= m_valid;
            r_we     <= m_we;
            r_rd     <= m_rd;
            r_sel    <= m_sel;
            r_src    <= m_src;
            r_addrLo <= m_addr_lo;
            r_ldType <= m_ld_type;
        end
    end

    logic [DATA_W-1:0] w_srcArr [NSRC];

    for (genvar k = 0; k < NSRC; k++) begin : g_unpack
        assign w_srcArr[k] = r_src[k*DATA_W +: DATA_W];
    end

    // Out-of-range selects fall through to the zero default.
    logic [DATA_W-1:0] w_selData;
    always_comb begin
        w_selData = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (r_sel == SEL_W'(k)) w_selData = w_srcArr[k];
        end
    end

    logic [DATA_W-1:0] w_ldData;

`ifdef W_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (r_addrLo)
            2'd0:    w_byte = w_selData[7:0];
            2'd1:    w_byte = w_selData[15:8];
            2'd2:    w_byte = w_selData[23:16];
            default: w_byte = w_selData[31:24];
        endcase
        w_half = r_addrLo[1] ? w_selData[31:16] : w_selData[15:0];
    end

    always_comb begin
        w_ldData = w_selData;
        case (r_ldType)
            c_LD_LB:  w_ldData = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_LD_LBU: w_ldData = {{(DATA_W-8){1'b0}}, w_byte};
            c_LD_LH:  w_ldData = {{(DATA_W-16){w_half[15]}}, w_half};
            c_LD_LHU: w_ldData = {{(DATA_W-16){1'b0}}, w_half};
            default:  w_ldData = w_selData;
        endcase
    end
`else
    // Load type and address bits are captured but have no effect in this build.
    logic w_unusedLoadBits;
    assign w_unusedLoadBits = ^{r_addrLo, r_ldType, c_LD_LB, c_LD_LBU, c_LD_LH, c_LD_LHU};
    assign w_ldData         = w_selData;
`endif

    logic [DATA_W-1:0] w_wdataPre;
    assign w_wdataPre = (r_sel == SEL_W'(LOAD_IDX)) ? w_ldData : w_selData;

    assign w_rf_we    = r_valid & r_we & (r_rd != 5'd0);
    assign w_rf_addr  = r_rd;
    assign w_rf_wdata = w_rf_we ? w_wdataPre : '0;
    assign w_valid    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_w_reg_write_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_w_reg_write_stage
// Description : Directed self-checking bench for w_reg_write_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w_reg_write_stage;

    localparam int DATA_W = 32;
    localparam int NSRC   = 4;
    localparam int SEL_W  = 3;

    logic                   clk;
    logic                   reset;
    logic                   stall;
    logic                   flush;
    logic                   m_valid;
    logic                   m_we;
    logic [4:0]             m_rd;
    logic [SEL_W-1:0]       m_sel;
    logic [NSRC*DATA_W-1:0] m_src;
    logic [1:0]             m_addr_lo;
    logic [2:0]             m_ld_type;
    logic                   w_rf_we;
    logic [4:0]             w_rf_addr;
    logic [DATA_W-1:0]      w_rf_wdata;
    logic                   w_valid;

    int nVec;
    int nFail;

    // {valid, we, addr, wdata}
    logic [38:0] obs;
    logic [38:0] exp;
    assign obs = {w_valid, w_rf_we, w_rf_addr, w_rf_wdata};

    w_reg_write_stage #(
        .DATA_W  (DATA_W),
        .NSRC    (NSRC),
        .SEL_W   (SEL_W),
        .LOAD_IDX(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_we      (m_we),
        .m_rd      (m_rd),
        .m_sel     (m_sel),
        .m_src     (m_src),
        .m_addr_lo (m_addr_lo),
        .m_ld_type (m_ld_type),
        .w_rf_we   (w_rf_we),
        .w_rf_addr (w_rf_addr),
        .w_rf_wdata(w_rf_wdata),
        .w_valid   (w_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [2:0] sel, input logic [1:0] lo, input logic [2:0] lt);
        m_valid   = v;
        m_we      = we;
        m_rd      = rd;
        m_sel     = sel;
        m_addr_lo = lo;
        m_ld_type = lt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        m_src = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        drive(1'b1, 1'b1, 5'd3, 3'd0, 2'd0, 3'd0);
        step();
        step();
        exp = 39'd0;
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        reset = 1'b0;
    endtask

    task automatic test_capture();
        m_src = {32'hCAFEF00D, 32'hDEADBEEF, 32'h0BADF00D, 32'h12345678};
        drive(1'b1, 1'b1, 5'd5, 3'd0, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd5, 32'h12345678};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL capture_src0: got %h expected %h", obs, exp);
        end
        drive(1'b1, 1'b1, 5'd31, 3'd2, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd31, 32'hDEADBEEF};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL capture_src2: got %h expected %h", obs, exp);
        end
        drive(1'b1, 1'b1, 5'd17, 3'd3, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd17, 32'hCAFEF00D};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL capture_src3: got %h expected %h", obs, exp);
        end
        drive(1'b1, 1'b0, 5'd8, 3'd0, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b0, 5'd8, 32'h0};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL capture_we0: got %h expected %h", obs, exp);
        end
        drive(1'b0, 1'b1, 5'd9, 3'd0, 2'd0, 3'd0);
        step();
        exp = {1'b0, 1'b0, 5'd9, 32'h0};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL capture_invalid: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_stall();
        m_src = {32'h44444444, 32'h33333333, 32'h22222222, 32'h12345678};
        drive(1'b1, 1'b1, 5'd0, 3'd0, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b0, 5'd0, 32'h0};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL rd0_suppress: got %h expected %h", obs, exp);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_src = {32'h0, 32'h0, 32'h0, 32'hA5A50000 + i};
            drive(1'b1, 1'b1, 5'd20 + 5'(i), 3'd0, 2'd0, 3'd0);
            step();
            nVec++;
            if (obs !== exp) begin
                nFail++;
                $display("FAIL stall_rd0_hold%0d: got %h expected %h", i, obs, exp);
            end
        end
        stall = 1'b0;
        m_src = {32'h0, 32'h0, 32'h0, 32'h0F0F1234};
        drive(1'b1, 1'b1, 5'd7, 3'd0, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd7, 32'h0F0F1234};
        stall = 1'b1;
        m_src = {32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};
        drive(1'b0, 1'b0, 5'd1, 3'd2, 2'd0, 3'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            nVec++;
            if (obs !== exp) begin
                nFail++;
                $display("FAIL stall_data_hold%0d: got %h expected %h", i, obs, exp);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_flush();
        m_src = {32'h0, 32'h0, 32'h0, 32'h55AA55AA};
        drive(1'b1, 1'b1, 5'd9, 3'd0, 2'd0, 3'd0);
        step();
        flush = 1'b1; stall = 1'b1;
        step();
        exp = {1'b0, 1'b0, 5'd9, 32'h0};
        nVec++;
        if (obs[38:37] !== exp[38:37] || w_rf_wdata !== 32'h0) begin
            nFail++;
            $display("FAIL flush_and_stall: got %h expected valid/we=0 wdata=0", obs);
        end
        stall = 1'b0;
        drive(1'b1, 1'b1, 5'd10, 3'd0, 2'd0, 3'd0);
        step();
        nVec++;
        if (obs[38:37] !== 2'b00 || w_rf_wdata !== 32'h0) begin
            nFail++;
            $display("FAIL flush_only: got %h expected valid/we=0 wdata=0", obs);
        end
        flush = 1'b0;
        m_src = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        drive(1'b1, 1'b1, 5'd3, 3'd7, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd3, 32'h0};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL sel_out_of_range: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_load();
        logic [31:0] e [5];
`ifdef W_LOAD_EXT_EN
        e[0] = 32'hFFFFFF80; e[1] = 32'h00000080; e[2] = 32'hFFFF80FF;
        e[3] = 32'h00007F01; e[4] = 32'h80FF7F01;
`else
        e[0] = 32'h80FF7F01; e[1] = 32'h80FF7F01; e[2] = 32'h80FF7F01;
        e[3] = 32'h80FF7F01; e[4] = 32'h80FF7F01;
`endif
        m_src = {32'h0, 32'h0, 32'h80FF7F01, 32'h0};
        drive(1'b1, 1'b1, 5'd4, 3'd1, 2'd3, 3'd1);
        step();
        exp = {1'b1, 1'b1, 5'd4, e[0]};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL load_lb: got %h expected %h", obs, exp);
        end
        drive(1'b1, 1'b1, 5'd4, 3'd1, 2'd3, 3'd2);
        step();
        exp = {1'b1, 1'b1, 5'd4, e[1]};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL load_lbu: got %h expected %h", obs, exp);
        end
        drive(1'b1, 1'b1, 5'd4, 3'd1, 2'd2, 3'd3);
        step();
        exp = {1'b1, 1'b1, 5'd4, e[2]};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL load_lh: got %h expected %h", obs, exp);
        end
        drive(1'b1, 1'b1, 5'd4, 3'd1, 2'd0, 3'd4);
        step();
        exp = {1'b1, 1'b1, 5'd4, e[3]};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL load_lhu: got %h expected %h", obs, exp);
        end
        drive(1'b1, 1'b1, 5'd4, 3'd1, 2'd1, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd4, e[4]};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL load_lw: got %h expected %h", obs, exp);
        end
        // Extension applies only on the load source; src0 with ld_type=lb passes unchanged.
        m_src = {32'h0, 32'h0, 32'h80FF7F01, 32'h80FF7F01};
        drive(1'b1, 1'b1, 5'd6, 3'd0, 2'd3, 3'd1);
        step();
        exp = {1'b1, 1'b1, 5'd6, 32'h80FF7F01};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL nonload_src_lb: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_async_reset();
        m_src = {32'h0, 32'h0, 32'h0, 32'h13579BDF};
        drive(1'b1, 1'b1, 5'd11, 3'd0, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd11, 32'h13579BDF};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL pre_reset_capture: got %h expected %h", obs, exp);
        end
        #2;
        reset = 1'b1;
        #1;
        exp = 39'd0;
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL async_reset: got %h expected %h", obs, exp);
        end
        stall = 1'b1; flush = 1'b1;
        step();
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL reset_over_stall_flush: got %h expected %h", obs, exp);
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        m_src = {32'h0, 32'h0, 32'h0, 32'h2468ACE0};
        drive(1'b1, 1'b1, 5'd12, 3'd0, 2'd0, 3'd0);
        step();
        exp = {1'b1, 1'b1, 5'd12, 32'h2468ACE0};
        nVec++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL first_capture_after_reset: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        nVec  = 0;
        nFail = 0;
        test_reset();
        test_capture();
        test_stall();
        test_flush();
        test_load();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/w_reg_write_stage.md
W_REG_WRITE_STAGE -- requirements
Module: w_reg_write_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of each writeback source and of the register-file write data.
REQ-002 Parameter NSRC, default 4, number of writeback sources (legal 2..8).
REQ-003 Parameter SEL_W, default 3, width of the source select; SHALL satisfy 2**SEL_W >= NSRC.
REQ-004 Parameter LOAD_IDX, default 1, index of the source that carries memory load data.
REQ-005 Timing is fixed: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 stall  in  1  hold the W register contents.
REQ-009 flush  in  1  load a bubble into the W register.
REQ-010 m_valid  in  1  M-stage instruction is valid.
REQ-011 m_we  in  1  M-stage instruction writes the register file.
REQ-012 m_rd  in  5  M-stage destination register.
REQ-013 m_sel  in  SEL_W  M-stage writeback source select.
REQ-014 m_src  in  NSRC*DATA_W  packed sources; source k occupies bits [k*DATA_W +: DATA_W].
REQ-015 m_addr_lo  in  2  low bits of the load address.
REQ-016 m_ld_type  in  3  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu; 5..7 are treated as lw.
REQ-017 w_rf_we  out  1  register-file write enable.
REQ-018 w_rf_addr  out  5  register-file write address.
REQ-019 w_rf_wdata  out  DATA_W  register-file write data.
REQ-020 w_valid  out  1  the W stage holds a valid instruction.

Function
REQ-021 The block SHALL contain one pipeline register (W) capturing m_valid, m_we, m_rd, m_sel, all m_src, m_addr_lo and m_ld_type; latency is 1 cycle from the M inputs to the W outputs.
REQ-022 Edge priority SHALL be: reset, then flush (capture a bubble with valid=0 and we=0, other fields don't-care), then stall (hold all fields), then capture.
REQ-023 Simultaneous flush and stall SHALL produce a bubble.
REQ-024 w_valid SHALL equal the registered valid.
REQ-025 w_rf_addr SHALL equal the registered rd.
REQ-026 w_rf_we SHALL be registered valid AND registered we AND (registered rd != 0).
REQ-027 w_rf_wdata SHALL be combinational from W: the selected source, or all-zero when registered sel >= NSRC.
REQ-028 When sel == LOAD_IDX, the load-extension rule (REQ-033/034) SHALL apply before the output.
REQ-029 w_rf_wdata SHALL be forced to 0 when w_rf_we is 0.

Reset
REQ-030 On reset, all W fields SHALL clear to 0 asynchronously, so w_rf_we=0, w_rf_addr=0, w_rf_wdata=0 and w_valid=0 immediately.
REQ-031 Reset asserted mid-stall or mid-flush SHALL override both; the first capture happens on the first rising edge after reset deasserts with stall=0 and flush=0.

Configuration
REQ-032 Macro W_LOAD_EXT_EN SHALL select whether load extension is compiled in.
REQ-033 With W_LOAD_EXT_EN defined, load extension SHALL behave as follows:
- lb/lbu select byte m_addr_lo (from the registered value) and sign- or zero-extend it to DATA_W.
- lh/lhu select half-word addr_lo[1] and sign- or zero-extend it to DATA_W.
- lw passes the word unchanged; addr_lo is ignored.
REQ-034 Without W_LOAD_EXT_EN, the load source SHALL pass unchanged regardless of ld_type and addr_lo.

Verification
REQ-035 Reset, then capture valid=1, we=1, rd=5, sel=0, src0=0x12345678 -> next cycle w_rf_we=1, addr=5, wdata=0x12345678, w_valid=1.
REQ-036 Capture rd=0, we=1, valid=1 -> w_rf_we=0 and wdata=0; then stall=1 for 3 cycles while the M inputs change -> the W outputs are unchanged for all 3 cycles.
REQ-037 With the W register holding a valid instruction, assert flush=1 and stall=1 together -> next cycle w_valid=0, w_rf_we=0; sel=7 with NSRC=4 -> wdata=0.
REQ-038 With W_LOAD_EXT_EN, sel=1, src1=0x80FF7F01:
- lb with addr_lo=3 -> 0xFFFFFF80.
- lbu with addr_lo=3 -> 0x00000080.
- lh with addr_lo=2 -> 0xFFFF80FF.
- lhu with addr_lo=0 -> 0x00007F01.
REQ-039 Without W_LOAD_EXT_EN, the same lb stimulus -> 0x80FF7F01.
REQ-040 Assert reset asynchronously between clock edges while w_rf_we=1 -> all outputs 0 before the next edge.
